// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the ram_arbiter block: FSM state encoding,
// counter widths and the one-hot index decoder used for grant vectors.
package ram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int HCNT_W  = 8;   // beats-in-quantum counter width
  localparam int STAT_W  = 16;  // per-requester statistics counter width
  localparam int IDX_W   = 3;   // requester index width (NREQ up to 8)
  localparam int MAX_REQ = 8;

  // Decode a requester index into a one-hot vector of MAX_REQ bits.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v = 8'b0000_0001 << idx;
    return v;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req starting one past 'last' and
// wrapping modulo NREQ; the first set bit wins. Callers mask out any
// requester that must not be chosen.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] win,
  output logic             valid
);

  int              cand;
  logic [NREQ-1:0] shifted;
  logic            hit;

  // Walk the candidates in priority order and latch the first requester seen.
  always_comb begin
    valid   = 1'b0;
    win     = '0;
    cand    = 0;
    shifted = '0;
    hit     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand    = (int'(last) + k) % NREQ;
      shifted = req >> cand;
      hit     = ~valid & shifted[0];
      win     = hit ? IDX_W'(cand) : win;
      valid   = valid | hit;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin owner of one dual-port RAM shared by NREQ
// requesters. The owner keeps the grant for up to HOLD_MAX beats, then the
// grant rotates to the next pending requester with no dead cycle.
// Optional build macro RAM_ARB_STATS_EN adds per-requester saturating beat
// counters (GNT_CNT) with a synchronous clear (STATS_CLR).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DWID     = 32,
  parameter int AWID     = 10,
  parameter int HOLD_MAX = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      REQ_WE,
  input  logic [NREQ*AWID-1:0] REQ_ADR,
  input  logic [NREQ*DWID-1:0] REQ_WDAT,
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      ACK,
  output logic [NREQ-1:0]      RVLD,
  output logic [DWID-1:0]      RDAT,
  output logic                 RAM_WRENA,
  output logic [AWID-1:0]      RAM_WRADR,
  output logic [DWID-1:0]      RAM_WRDAT,
  output logic                 RAM_RDENA,
  output logic [AWID-1:0]      RAM_RDADR,
  input  logic [DWID-1:0]      RAM_RDDAT
`ifdef RAM_ARB_STATS_EN
  ,
  input  logic                 STATS_CLR,
  output logic [NREQ*STAT_W-1:0] GNT_CNT
`endif
);

  state_t              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     rvld_q, rvld_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [HCNT_W-1:0]   hold_q, hold_d;
  logic [DWID-1:0]     rdat_q, rdat_d;

  logic                own_req_s;
  logic                own_we_s;
  logic [AWID-1:0]     own_adr_s;
  logic [DWID-1:0]     own_wdat_s;
  logic                acc_s;
  logic [NREQ-1:0]     pick_req_s;
  logic [IDX_W-1:0]    pick_last_s;
  logic [IDX_W-1:0]    pick_win_s;
  logic                pick_vld_s;
  logic [NREQ-1:0]     gnt_win_s;

  // Select the owner's request fields; gnt_q is one-hot so an OR-mux suffices.
  always_comb begin
    own_req_s  = 1'b0;
    own_we_s   = 1'b0;
    own_adr_s  = '0;
    own_wdat_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      own_req_s  = own_req_s | (gnt_q[i] & REQ[i]);
      own_we_s   = own_we_s  | (gnt_q[i] & REQ_WE[i]);
      own_adr_s  = own_adr_s  | ({AWID{gnt_q[i]}} & REQ_ADR[i*AWID +: AWID]);
      own_wdat_s = own_wdat_s | ({DWID{gnt_q[i]}} & REQ_WDAT[i*DWID +: DWID]);
    end
  end

  // An access happens only in OWN with the owner requesting; this gates every RAM enable.
  assign acc_s = (state_q == OWN) & own_req_s;

  // One picker serves both decisions: from IDLE it scans past last_owner,
  // while owning it scans past the owner with the owner masked out.
  assign pick_req_s  = (state_q == OWN) ? (REQ & ~gnt_q) : REQ;
  assign pick_last_s = (state_q == OWN) ? owner_q : last_q;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (pick_req_s),
    .last  (pick_last_s),
    .win   (pick_win_s),
    .valid (pick_vld_s)
  );

  assign gnt_win_s = NREQ'(onehot(pick_win_s));

  // Next-state logic for ownership, quantum counting and the read-return path.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    rvld_d  = '0;
    rdat_d  = rdat_q;

    if (acc_s && !own_we_s) begin
      rvld_d = gnt_q;
      rdat_d = RAM_RDDAT;
    end else begin
      rvld_d = '0;
      rdat_d = rdat_q;
    end

    case (state_q)
      IDLE: begin
        if (pick_vld_s) begin
          state_d = OWN;
          gnt_d   = gnt_win_s;
          owner_d = pick_win_s;
          hold_d  = '0;
        end else begin
          gnt_d   = '0;
        end
      end
      OWN: begin
        if (acc_s) begin
          if (hold_q == HCNT_W'(HOLD_MAX - 1)) begin
            hold_d = '0;
            if (pick_vld_s) begin
              last_d  = owner_q;
              gnt_d   = gnt_win_s;
              owner_d = pick_win_s;
            end else begin
              gnt_d   = gnt_q;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end else begin
          // Owner released: hand over immediately, or fall back to IDLE.
          hold_d = '0;
          last_d = owner_q;
          if (pick_vld_s) begin
            gnt_d   = gnt_win_s;
            owner_d = pick_win_s;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State and registered outputs; async reset makes requester 0 win first.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rvld_q  <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      hold_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rvld_q  <= rvld_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      rdat_q  <= rdat_d;
    end
  end

  assign GNT       = gnt_q;
  assign ACK       = {NREQ{acc_s}} & gnt_q;
  assign RVLD      = rvld_q;
  assign RDAT      = rdat_q;
  assign RAM_WRENA = acc_s & own_we_s;
  assign RAM_RDENA = acc_s & ~own_we_s;
  assign RAM_WRADR = own_adr_s;
  assign RAM_RDADR = own_adr_s;
  assign RAM_WRDAT = own_wdat_s;

`ifdef RAM_ARB_STATS_EN
  logic [NREQ*STAT_W-1:0] cnt_q, cnt_d;

  // Saturating per-requester beat counters; a clear wins over a same-cycle ACK.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (STATS_CLR) begin
        cnt_d[i*STAT_W +: STAT_W] = '0;
      end else if (ACK[i] && (cnt_q[i*STAT_W +: STAT_W] != 16'hFFFF)) begin
        cnt_d[i*STAT_W +: STAT_W] = cnt_q[i*STAT_W +: STAT_W] + 16'd1;
      end else begin
        cnt_d[i*STAT_W +: STAT_W] = cnt_q[i*STAT_W +: STAT_W];
      end
    end
  end

  // Counter storage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign GNT_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter (default build). A behavioural model
// tracks the owner as an integer, counts beats used in the quantum and keeps
// its own copy of the low 16 RAM words; every cycle the DUT outputs are
// compared against it. Directed scenarios are followed by random traffic.
module tb_ram_arbiter;

  localparam int NREQ     = 4;
  localparam int DWID     = 32;
  localparam int AWID     = 10;
  localparam int HOLD_MAX = 4;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic [NREQ-1:0]      REQ;
  logic [NREQ-1:0]      REQ_WE;
  logic [NREQ*AWID-1:0] REQ_ADR;
  logic [NREQ*DWID-1:0] REQ_WDAT;
  logic [NREQ-1:0]      GNT, ACK, RVLD;
  logic [DWID-1:0]      RDAT;
  logic                 RAM_WRENA, RAM_RDENA;
  logic [AWID-1:0]      RAM_WRADR, RAM_RDADR;
  logic [DWID-1:0]      RAM_WRDAT, RAM_RDDAT;

  ram_arbiter #(.NREQ(NREQ), .DWID(DWID), .AWID(AWID), .HOLD_MAX(HOLD_MAX)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADR(REQ_ADR),
    .REQ_WDAT(REQ_WDAT), .GNT(GNT), .ACK(ACK), .RVLD(RVLD), .RDAT(RDAT),
    .RAM_WRENA(RAM_WRENA), .RAM_WRADR(RAM_WRADR), .RAM_WRDAT(RAM_WRDAT),
    .RAM_RDENA(RAM_RDENA), .RAM_RDADR(RAM_RDADR), .RAM_RDDAT(RAM_RDDAT)
  );

  always #5 CLK = ~CLK;

  // RAM: write on the clock edge, combinational read; a bench preload port shares the write side.
  logic [DWID-1:0] ram [0:1023];
  logic            pre_we;
  logic [AWID-1:0] pre_adr;
  logic [DWID-1:0] pre_dat;
  always @(posedge CLK) begin
    if (pre_we) ram[pre_adr] <= pre_dat;
    else if (RAM_WRENA) ram[RAM_WRADR] <= RAM_WRDAT;
  end
  assign RAM_RDDAT = ram[RAM_RDADR];

  // Requester-side stimulus, one entry per requester.
  logic [NREQ-1:0] r_req, r_we;
  logic [AWID-1:0] r_adr [NREQ];
  logic [DWID-1:0] r_wd  [NREQ];

  // Reference model state.
  int              m_own;     // owner index, -1 when nobody holds the RAM
  int              m_beats;   // beats already used in the current quantum
  int              m_last;    // previous owner, round-robin starts after it
  int              m_rvld;    // requester whose read returns now, -1 if none
  logic [DWID-1:0] m_rdat;
  logic [DWID-1:0] em [16];
  logic [NREQ-1:0] prev_ack;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] rq, input int after, input int excl);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (after + k) % NREQ;
      if (j != excl && rq[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_beats = 0; m_last = NREQ - 1; m_rvld = -1; m_rdat = '0; prev_ack = '0;
  endtask

  task automatic pack();
    REQ = r_req;
    REQ_WE = r_we;
    for (int i = 0; i < NREQ; i++) begin
      REQ_ADR[i*AWID +: AWID]  = r_adr[i];
      REQ_WDAT[i*DWID +: DWID] = r_wd[i];
    end
  endtask

  // Compare the current cycle against the model, then advance the model and
  // move to the next falling edge (the rising edge happens in between).
  task automatic step();
    logic [NREQ-1:0] e_gnt, e_ack, e_rvld;
    logic            acc, we;
    int              a, nxt, nr;
    pack();
    #1;
    e_gnt = '0; e_ack = '0; e_rvld = '0;
    if (m_own >= 0) e_gnt[m_own] = 1'b1;
    acc = (m_own >= 0) && r_req[m_own];
    we  = acc && r_we[m_own];
    a   = acc ? int'(r_adr[m_own]) : 0;
    if (acc) e_ack = e_gnt;
    if (m_rvld >= 0) e_rvld[m_rvld] = 1'b1;
    chk("GNT", 64'(GNT), 64'(e_gnt));
    chk("ACK", 64'(ACK), 64'(e_ack));
    chk("RVLD", 64'(RVLD), 64'(e_rvld));
    chk("RDAT", 64'(RDAT), 64'(m_rdat));
    chk("WRENA", 64'(RAM_WRENA), 64'(we));
    chk("RDENA", 64'(RAM_RDENA), 64'(acc && !we));
    if (we) begin
      chk("WRADR", 64'(RAM_WRADR), 64'(a));
      chk("WRDAT", 64'(RAM_WRDAT), 64'(r_wd[m_own]));
    end
    if (acc && !we) chk("RDADR", 64'(RAM_RDADR), 64'(a));

    prev_ack = e_ack;
    nr = -1;
    if (acc && !we) begin nr = m_own; m_rdat = em[a]; end
    if (we) em[a] = r_wd[m_own];
    if (pre_we) em[int'(pre_adr)] = pre_dat;
    if (m_own < 0) begin
      nxt = pick(r_req, m_last, -1);
      if (nxt >= 0) begin m_own = nxt; m_beats = 0; end
    end else begin
      nxt = pick(r_req, m_own, m_own);
      if (acc) begin
        m_beats++;
        if (m_beats == HOLD_MAX) begin
          m_beats = 0;
          if (nxt >= 0) begin m_last = m_own; m_own = nxt; end
        end
      end else begin
        m_beats = 0;
        m_last  = m_own;
        m_own   = nxt;
      end
    end
    m_rvld = nr;
    @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0;
    pre_we = 1'b0; pre_adr = '0; pre_dat = '0;
    r_req = '0; r_we = '0;
    for (int i = 0; i < NREQ; i++) begin r_adr[i] = '0; r_wd[i] = '0; end
    pack();
    model_reset();
    #2;
    chk("RST_GNT", 64'(GNT), 64'd0);
    chk("RST_RVLD", 64'(RVLD), 64'd0);
    chk("RST_RDAT", 64'(RDAT), 64'd0);
    chk("RST_WRENA", 64'(RAM_WRENA), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Preload words 0..15 (word 9 = 0xA5) while the arbiter is idle.
    for (int a = 0; a < 16; a++) begin
      pre_we  = 1'b1;
      pre_adr = AWID'(a);
      pre_dat = (a == 9) ? 32'h0000_00A5 : (32'hC0DE_0000 | 32'(a));
      step();
    end
    pre_we = 1'b0;

    // Requester 0 write burst: 5/6/7 <- 0x11/0x22/0x33.
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_adr[0] = 10'd5; r_wd[0] = 32'h11;
    step();
    step();
    r_adr[0] = 10'd6; r_wd[0] = 32'h22; step();
    r_adr[0] = 10'd7; r_wd[0] = 32'h33; step();
    r_req[0] = 1'b0; step();
    chk("RAM5", 64'(ram[5]), 64'h11);
    chk("RAM6", 64'(ram[6]), 64'h22);
    chk("RAM7", 64'(ram[7]), 64'h33);

    // Requester 2 reads word 9.
    r_req[2] = 1'b1; r_we[2] = 1'b0; r_adr[2] = 10'd9;
    step();
    step();
    r_req[2] = 1'b0;
    pack();
    #1;
    chk("RD9_RVLD", 64'(RVLD), 64'b0100);
    chk("RD9_RDAT", 64'(RDAT), 64'hA5);
    step();
    step();

    // Owner drops after one beat with another requester pending, then all quiet.
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_adr[0] = 10'd3;
    r_req[1] = 1'b1; r_we[1] = 1'b1; r_adr[1] = 10'd4; r_wd[1] = 32'hBEEF_0004;
    step();
    step();
    r_req[0] = 1'b0; step();
    step();
    r_req[1] = 1'b0; step();
    step();

    // All requesters saturate the RAM: grants rotate every HOLD_MAX beats.
    r_req = '1;
    for (int c = 0; c < 4 * HOLD_MAX * NREQ + 2; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        r_we[i] = 1'($urandom_range(0, 1));
        r_adr[i] = AWID'($urandom_range(0, 15));
        r_wd[i] = $urandom;
      end
      step();
    end
    r_req = '0; step(); step();

    // Reset in the middle of a write burst.
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_adr[0] = 10'd12; r_wd[0] = 32'h1234_0001;
    step();
    step();
    r_wd[0] = 32'h1234_0002; r_adr[0] = 10'd13;
    pack();
    #1;
    RST_N = 1'b0;
    #1;
    chk("MIDRST_GNT", 64'(GNT), 64'd0);
    chk("MIDRST_ACK", 64'(ACK), 64'd0);
    chk("MIDRST_RVLD", 64'(RVLD), 64'd0);
    chk("MIDRST_WRENA", 64'(RAM_WRENA), 64'd0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    r_req = '0; r_req[3] = 1'b1; r_req[0] = 1'b1; r_we[0] = 1'b0; r_we[3] = 1'b0;
    RST_N = 1'b1;
    step();
    chk("POSTRST_GNT0", 64'(GNT), 64'b0001);
    chk("RAM13_NOWRITE", 64'(ram[13]), 64'(em[13]));
    step();

    // Random traffic: a request is held until acknowledged, then re-rolled.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(r_req[i] && !prev_ack[i])) begin
          r_req[i] = ($urandom_range(0, 99) < 55);
          r_we[i]  = 1'($urandom_range(0, 1));
          r_adr[i] = AWID'($urandom_range(0, 15));
          r_wd[i]  = $urandom;
        end
      end
      step();
    end
    r_req = '0; step(); step();
    for (int a = 0; a < 16; a++) chk("RAM_FINAL", 64'(ram[a]), 64'(em[a]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin arbiter that shares one dual-port `ram` instance (write and read ports on the same clock) between NREQ requesters.
- Each requester issues single-beat read or write accesses and holds ownership for at most HOLD_MAX beats, after which ownership rotates.
- Sits between DMA or register clients and the RAM; drives the RAM's WRENA/WRADR/WRDAT/RDENA/RDADR and samples RDDAT.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWID, 32, data width.
- AWID, 10, RAM address width.
- HOLD_MAX, 4, maximum beats per grant quantum (1..255).

Ports:
- CLK  in  1  single clock, shared with the RAM's WRCLK/RDCLK.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NREQ  per-requester access request, held until ACK.
- REQ_WE  in  NREQ  1 = write, 0 = read.
- REQ_ADR  in  NREQ*AWID  packed addresses; requester i uses slice [i*AWID +: AWID].
- REQ_WDAT  in  NREQ*DWID  packed write data.
- GNT  out  NREQ  one-hot ownership, registered.
- ACK  out  NREQ  access performed this cycle (GNT[i] & REQ[i]).
- RVLD  out  NREQ  read data valid pulse.
- RDAT  out  DWID  registered read data.
- RAM_WRENA / RAM_WRADR / RAM_WRDAT  out  1 / AWID / DWID  RAM write port.
- RAM_RDENA / RAM_RDADR  out  1 / AWID  RAM read port.
- RAM_RDDAT  in  DWID  RAM read data, combinational from RAM_RDADR.

Behaviour:
- Reset (async, RST_N=0): state=IDLE, GNT=0, RVLD=0, RDAT=0, hold_cnt=0, last_owner=NREQ-1 (requester 0 wins first). ACK and RAM_* enables are 0 while state is IDLE.
- IDLE: any REQ high → pick the winner by round-robin starting at last_owner+1 modulo NREQ; next edge state=OWN, GNT=onehot(winner), hold_cnt=0. No access occurs in IDLE, so first-access latency is one cycle after REQ.
- OWN, owner REQ high:
  - ACK[owner]=1 combinationally.
  - RAM_WRENA=REQ_WE[owner] and RAM_RDENA=!REQ_WE[owner].
  - Addresses and data are muxed from the owner's slices.
  - hold_cnt increments.
- OWN, quantum end (access with hold_cnt==HOLD_MAX-1):
  - If other requesters are pending → rotate next edge; last_owner=owner, new GNT=RR pick excluding owner. No dead cycle between owners.
  - If only the owner is pending → keep the grant, hold_cnt=0.
- OWN, owner REQ low: no access this cycle.
  - If others are pending → rotate next edge.
  - Else → IDLE, GNT=0.
- Read path: on a read ACK, RDAT<=RAM_RDDAT and RVLD[owner]<=1 at the next edge; RVLD is a 1-cycle pulse. RDAT holds its value otherwise.
- Write path: the write commits in the RAM at the ACK edge. A same-address read by the next owner on the following cycle returns the new data.
- Only GNT-qualified requests are ever ACKed. A requester changing ADR/WE/WDAT while not granted has no effect.
- HOLD_MAX=1 gives pure per-beat round-robin.
- hold_cnt width is 8 bits; it never exceeds HOLD_MAX-1.
- Reset asserted mid-burst: all outputs clear immediately (async). No partial write: the RAM_WRENA combinational term is gated by state.

Optional Feature:
- RAM_ARB_STATS_EN defined:
  - Adds output GNT_CNT (NREQ*16): per-requester saturating 16-bit count of ACKed beats.
  - Adds input STATS_CLR, which synchronously zeroes all counts.
  - Counts reset to 0 by RST_N.
  - Counts saturate at 16'hFFFF.
  - STATS_CLR and ACK in the same cycle → count=0.
- Not defined: no GNT_CNT/STATS_CLR ports and no counter logic.

Decomposition:
- Package ram_arb_pkg holds:
  - enum state_t {IDLE, OWN};
  - localparam HCNT_W=8;
  - localparam STAT_W=16;
  - a function onehot(idx).
- One sub-module, rr_pick: combinational, inputs req vector and last_owner index, outputs winner index and valid. Reused for both the IDLE and rotate decisions.

Test Plan:
- REQ[0]=1, WE=1, ADR 5,6,7 over 3 beats, data 0x11/0x22/0x33 → GNT[0] at cycle 1; ACK[0] at cycles 1–3; RAM_WRENA 3 cycles; RAM holds 0x11/0x22/0x33.
- All 4 REQ held high, HOLD_MAX=4 → GNT sequence 0,1,2,3,0, each with exactly 4 ACKs, no idle cycles between owners.
- RAM[9]=0xA5, REQ[2] read ADR 9 → ACK[2] at cycle N, RVLD[2]=1 and RDAT=0xA5 at cycle N+1, RVLD low at N+2.
- REQ[0] drops after 1 beat while REQ[1] is pending → GNT[1] on the next cycle. With no other requests pending → IDLE, GNT=0.
- RST_N pulled low during the 2nd beat of a write burst → GNT/RVLD/RAM_WRENA=0 immediately. After release with REQ[3] and REQ[0] both high → requester 0 granted first.
- RAM_ARB_STATS_EN: 70000 continuous beats from requester 1 → GNT_CNT[1]=0xFFFF. STATS_CLR pulse → 0.
